// File: rtl/me_pad_deser.sv
// Pad-side deserializer for the motion-estimation core: builds WriteData / bufferData_in
// from multi-beat narrow pad transfers and queues outgoing motion vectors in a small FIFO.
module me_pad_deser #(
    parameter int PAD_W     = 8,
    parameter int WD_W      = 88,
    parameter int BD_W      = 32,
    parameter int VEC_W     = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [PAD_W-1:0] pad_data,
    input  logic             pad_valid,
    input  logic             pad_sof,
    input  logic             pad_sel,
    output logic [WD_W-1:0]  WriteData,
    output logic             wd_valid,
    output logic [BD_W-1:0]  bufferData_in,
    output logic             bd_valid,
    output logic             sync_err,
    input  logic             vec_in_valid,
    input  logic [VEC_W-1:0] vec_in_x,
    input  logic [VEC_W-1:0] vec_in_y,
    output logic [VEC_W-1:0] vector_x,
    output logic [VEC_W-1:0] vector_y,
    output logic             vec_out_valid,
    input  logic             vec_out_ready,
    output logic             vec_ovf
);

    localparam int WD_BEATS = (WD_W + PAD_W - 1) / PAD_W;
    localparam int BD_BEATS = (BD_W + PAD_W - 1) / PAD_W;
    localparam int SH_W     = WD_BEATS * PAD_W;
    localparam int CNT_W    = $clog2(WD_BEATS + 1);
    localparam int PTR_W    = $clog2(OUT_DEPTH);
    localparam int FCNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, COLLECT_WD, COLLECT_BD} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   beat_cnt_reg;
    logic [PAD_W-1:0]   shadow_reg [WD_BEATS];
    logic [SH_W-1:0]    word_next;
    logic               shadow_wr;
    logic [CNT_W-1:0]   shadow_idx;

    // A sof beat always lands in slot 0; other beats only count while collecting.
    assign shadow_wr  = pad_valid && (pad_sof || state_reg != IDLE);
    assign shadow_idx = pad_sof ? '0 : beat_cnt_reg;

    // word_next is the shadow with the current beat merged in, so the final beat
    // can be published on the same edge it arrives.
    generate
        for (genvar gi = 0; gi < WD_BEATS; gi++) begin : g_beat
            assign word_next[gi*PAD_W +: PAD_W] =
                (beat_cnt_reg == CNT_W'(gi)) ? pad_data : shadow_reg[gi];

            always_ff @(posedge CLK) begin
                if (shadow_wr && shadow_idx == CNT_W'(gi))
                    shadow_reg[gi] <= pad_data;
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            WriteData     <= '0;
            bufferData_in <= '0;
            wd_valid      <= 1'b0;
            bd_valid      <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            wd_valid <= 1'b0;
            bd_valid <= 1'b0;
            sync_err <= 1'b0;
            if (pad_valid && pad_sof) begin
                // An early sof abandons the word in flight and restarts on this beat.
                if (state_reg != IDLE)
                    sync_err <= 1'b1;
                state_reg    <= pad_sel ? COLLECT_BD : COLLECT_WD;
                beat_cnt_reg <= CNT_W'(1);
            end else if (pad_valid && state_reg != IDLE) begin
                if (state_reg == COLLECT_WD && beat_cnt_reg == CNT_W'(WD_BEATS - 1)) begin
                    WriteData    <= word_next[WD_W-1:0];
                    wd_valid     <= 1'b1;
                    state_reg    <= IDLE;
                    beat_cnt_reg <= '0;
                end else if (state_reg == COLLECT_BD && beat_cnt_reg == CNT_W'(BD_BEATS - 1)) begin
                    bufferData_in <= word_next[BD_W-1:0];
                    bd_valid      <= 1'b1;
                    state_reg     <= IDLE;
                    beat_cnt_reg  <= '0;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    logic [VEC_W-1:0]  fifo_x_mem [OUT_DEPTH];
    logic [VEC_W-1:0]  fifo_y_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [FCNT_W-1:0] count_reg;
    logic              fifo_full;
    logic              fifo_pop;
    logic              fifo_push;

    assign fifo_full     = (count_reg == FCNT_W'(OUT_DEPTH));
    assign vec_out_valid = (count_reg != '0);
    assign fifo_pop      = vec_out_valid && vec_out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifo_push     = vec_in_valid && (!fifo_full || fifo_pop);
    assign vector_x      = vec_out_valid ? fifo_x_mem[rd_ptr_reg] : '0;
    assign vector_y      = vec_out_valid ? fifo_y_mem[rd_ptr_reg] : '0;

    always_ff @(posedge CLK) begin
        if (fifo_push) begin
            fifo_x_mem[wr_ptr_reg] <= vec_in_x;
            fifo_y_mem[wr_ptr_reg] <= vec_in_y;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            vec_ovf    <= 1'b0;
        end else begin
            if (fifo_push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fifo_pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (fifo_push && !fifo_pop)
                count_reg <= count_reg + FCNT_W'(1);
            else if (fifo_pop && !fifo_push)
                count_reg <= count_reg - FCNT_W'(1);
            if (vec_in_valid && fifo_full && !fifo_pop)
                vec_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_me_pad_deser.sv
// Scoreboard bench for me_pad_deser: word assembly, resync on early sof, vector FIFO
// overflow / simultaneous push-pop, and asynchronous reset mid-transfer.
module tb_me_pad_deser;

    localparam int PAD_W = 8, WD_W = 88, BD_W = 32, VEC_W = 4, OUT_DEPTH = 4;

    logic             CLK = 1'b0;
    logic             reset;
    logic [PAD_W-1:0] pad_data;
    logic             pad_valid, pad_sof, pad_sel;
    logic [WD_W-1:0]  WriteData;
    logic             wd_valid;
    logic [BD_W-1:0]  bufferData_in;
    logic             bd_valid, sync_err;
    logic             vec_in_valid;
    logic [VEC_W-1:0] vec_in_x, vec_in_y, vector_x, vector_y;
    logic             vec_out_valid, vec_out_ready, vec_ovf;

    me_pad_deser #(.PAD_W(PAD_W), .WD_W(WD_W), .BD_W(BD_W), .VEC_W(VEC_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .CLK(CLK), .reset(reset), .pad_data(pad_data), .pad_valid(pad_valid),
        .pad_sof(pad_sof), .pad_sel(pad_sel), .WriteData(WriteData), .wd_valid(wd_valid),
        .bufferData_in(bufferData_in), .bd_valid(bd_valid), .sync_err(sync_err),
        .vec_in_valid(vec_in_valid), .vec_in_x(vec_in_x), .vec_in_y(vec_in_y),
        .vector_x(vector_x), .vector_y(vector_y), .vec_out_valid(vec_out_valid),
        .vec_out_ready(vec_out_ready), .vec_ovf(vec_ovf)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    int wd_pulses = 0, bd_pulses = 0, err_pulses = 0;
    logic [WD_W-1:0]      exp_wd  [$];
    logic [BD_W-1:0]      exp_bd  [$];
    logic [2*VEC_W-1:0]   exp_vec [$];
    logic [WD_W-1:0]      last_wd = '0;

    always @(negedge CLK) begin
        if (wd_valid === 1'b1) wd_pulses <= wd_pulses + 1;
        if (bd_valid === 1'b1) bd_pulses <= bd_pulses + 1;
        if (sync_err === 1'b1) err_pulses <= err_pulses + 1;
    end

    task automatic beat(input logic [7:0] d, input logic sof, input logic sel);
        pad_data = d; pad_valid = 1'b1; pad_sof = sof; pad_sel = sel;
        @(posedge CLK); #1;
        pad_data = '0; pad_valid = 1'b0; pad_sof = 1'b0; pad_sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Returns negedges waited before the pulse, or -1 if it never came.
    task automatic wait_pulse(input bit is_bd, output int lat);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if ((is_bd ? bd_valid : wd_valid) === 1'b1) begin lat = i; break; end
        end
        @(posedge CLK); #1;
    endtask

    task automatic send_wd(input logic [7:0] base);
        logic [WD_W-1:0] e;
        for (int k = 0; k < 11; k++) e[k*8 +: 8] = base + 8'(k);
        exp_wd.push_back(e);
        for (int k = 0; k < 11; k++) beat(base + 8'(k), k == 0, 1'b0);
    endtask

    task automatic pop_vec(input string name);
        logic [2*VEC_W-1:0] e;
        e = exp_vec.pop_front();
        checks++;
        if (vec_out_valid !== 1'b1 || {vector_x, vector_y} !== e) begin
            errors++;
            $display("FAIL %s got valid=%b vec=%h exp valid=1 vec=%h", name, vec_out_valid, {vector_x, vector_y}, e);
        end
        $display("vec pop %s x=%0d y=%0d", name, vector_x, vector_y);
        vec_out_ready = 1'b1; @(posedge CLK); #1; vec_out_ready = 1'b0;
    endtask

    task automatic check_wd(input string name);
        int lat; logic [WD_W-1:0] e;
        wait_pulse(1'b0, lat);
        e = exp_wd.pop_front();
        checks++;
        if (lat != 0) begin errors++; $display("FAIL %s_latency got %0d exp 0", name, lat); end
        checks++;
        if (WriteData !== e) begin errors++; $display("FAIL %s_data got %h exp %h", name, WriteData, e); end
        last_wd = e;
        $display("wd word %s %h", name, WriteData);
    endtask

    task automatic check_bd(input string name);
        int lat; logic [BD_W-1:0] e;
        wait_pulse(1'b1, lat);
        e = exp_bd.pop_front();
        checks++;
        if (lat != 0) begin errors++; $display("FAIL %s_latency got %0d exp 0", name, lat); end
        checks++;
        if (bufferData_in !== e) begin errors++; $display("FAIL %s_data got %h exp %h", name, bufferData_in, e); end
        $display("bd word %s %h", name, bufferData_in);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK); #1;
        checks++;
        if (WriteData !== '0 || bufferData_in !== '0 || wd_valid !== 1'b0 || bd_valid !== 1'b0 || sync_err !== 1'b0) begin
            errors++; $display("FAIL reset_words got wd=%h bd=%h v=%b%b%b exp all 0", WriteData, bufferData_in, wd_valid, bd_valid, sync_err);
        end
        reset = 1'b0;
        idle(1);
        checks++;
        if (vec_out_valid !== 1'b0 || vector_x !== '0 || vector_y !== '0 || vec_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_fifo got valid=%b x=%h y=%h ovf=%b exp 0", vec_out_valid, vector_x, vector_y, vec_ovf);
        end
        $display("reset released");
    endtask

    task automatic test_wd_word();
        int p0 = wd_pulses;
        send_wd(8'h01);
        check_wd("wd_basic");
        checks++;
        if (WriteData !== 88'h0B0A0908070605040302_01) begin
            errors++; $display("FAIL wd_known got %h exp 0b0a..01", WriteData);
        end
        idle(2);
        checks++;
        if (wd_pulses - p0 != 1) begin errors++; $display("FAIL wd_pulse_count got %0d exp 1", wd_pulses - p0); end
    endtask

    task automatic test_bd_stall();
        int p0 = bd_pulses;
        exp_bd.push_back(32'hEFBEADDE);
        beat(8'hDE, 1'b1, 1'b1);
        beat(8'hAD, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (bufferData_in !== '0 || bd_valid !== 1'b0) begin
            errors++; $display("FAIL bd_partial got %h valid=%b exp 0 valid=0", bufferData_in, bd_valid);
        end
        beat(8'hBE, 1'b0, 1'b0);
        beat(8'hEF, 1'b0, 1'b0);
        check_bd("bd_stall");
        idle(2);
        checks++;
        if (bd_pulses - p0 != 1) begin errors++; $display("FAIL bd_pulse_count got %0d exp 1", bd_pulses - p0); end
    endtask

    task automatic test_sync_err();
        int e0 = err_pulses, w0 = wd_pulses;
        for (int k = 0; k < 5; k++) beat(8'h21 + 8'(k), k == 0, 1'b0);
        exp_bd.push_back(32'h34333231);
        beat(8'h31, 1'b1, 1'b1);
        checks++;
        if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_err_pulse got %b exp 1", sync_err); end
        for (int k = 1; k < 4; k++) beat(8'h31 + 8'(k), 1'b0, 1'b0);
        check_bd("bd_after_resync");
        idle(2);
        checks++;
        if (err_pulses - e0 != 1 || wd_pulses != w0) begin
            errors++; $display("FAIL sync_err_counts got err=%0d wd=%0d exp err=1 wd=0", err_pulses - e0, wd_pulses - w0);
        end
        checks++;
        if (WriteData !== last_wd) begin errors++; $display("FAIL wd_unchanged got %h exp %h", WriteData, last_wd); end
    endtask

    task automatic test_idle_beat();
        int e0 = err_pulses, w0 = wd_pulses;
        beat(8'hFF, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (err_pulses != e0 || wd_pulses != w0 || bd_valid !== 1'b0) begin
            errors++; $display("FAIL idle_beat got err=%0d wd=%0d exp 0 0", err_pulses - e0, wd_pulses - w0);
        end
        send_wd(8'hA0);
        check_wd("wd_after_idle_beat");
    endtask

    task automatic test_fifo_overflow();
        for (int i = 1; i <= 5; i++) begin
            vec_in_valid = 1'b1; vec_in_x = 4'(i); vec_in_y = 4'(i);
            if (i <= OUT_DEPTH) exp_vec.push_back({4'(i), 4'(i)});
            @(posedge CLK); #1;
            if (i == OUT_DEPTH) begin
                checks++;
                if (vec_ovf !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b exp 0", vec_ovf); end
            end
        end
        vec_in_valid = 1'b0;
        checks++;
        if (vec_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", vec_ovf); end
        for (int i = 0; i < OUT_DEPTH; i++) pop_vec("ovf_drain");
        checks++;
        if (vec_out_valid !== 1'b0 || vector_x !== '0 || vector_y !== '0) begin
            errors++; $display("FAIL fifo_empty got valid=%b x=%h y=%h exp 0", vec_out_valid, vector_x, vector_y);
        end
        checks++;
        if (vec_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", vec_ovf); end
    endtask

    task automatic test_full_push_pop();
        reset = 1'b1; idle(1); reset = 1'b0; idle(1);
        for (int i = 1; i <= OUT_DEPTH; i++) begin
            vec_in_valid = 1'b1; vec_in_x = 4'(i); vec_in_y = 4'(i + 1);
            exp_vec.push_back({4'(i), 4'(i + 1)});
            @(posedge CLK); #1;
        end
        vec_in_valid = 1'b1; vec_in_x = 4'd7; vec_in_y = 4'd7;
        exp_vec.push_back(8'h77);
        pop_vec("full_push_pop");
        vec_in_valid = 1'b0;
        checks++;
        if (vec_ovf !== 1'b0) begin errors++; $display("FAIL ovf_push_pop got %b exp 0", vec_ovf); end
        for (int i = 0; i < OUT_DEPTH; i++) pop_vec("push_pop_drain");
        checks++;
        if (vec_out_valid !== 1'b0) begin errors++; $display("FAIL count_unchanged got valid=%b exp 0", vec_out_valid); end
        vec_out_ready = 1'b1; idle(1); vec_out_ready = 1'b0;
        vec_in_valid = 1'b1; vec_in_x = 4'd9; vec_in_y = 4'd3; exp_vec.push_back(8'h93);
        idle(1); vec_in_valid = 1'b0;
        pop_vec("after_empty_pop");
        checks++;
        if (vec_out_valid !== 1'b0 || vec_ovf !== 1'b0) begin
            errors++; $display("FAIL empty_pop_ignored got valid=%b ovf=%b exp 0 0", vec_out_valid, vec_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        for (int i = 0; i < 3; i++) begin
            vec_in_valid = 1'b1; vec_in_x = 4'(i + 4); vec_in_y = 4'(i + 8);
            @(posedge CLK); #1;
        end
        vec_in_valid = 1'b0;
        exp_bd.push_back(32'h11223344);
        beat(8'h44, 1'b1, 1'b1); beat(8'h33, 1'b0, 1'b0); beat(8'h22, 1'b0, 1'b0); beat(8'h11, 1'b0, 1'b0);
        check_bd("bd_before_reset");
        for (int k = 0; k < 6; k++) beat(8'h61 + 8'(k), k == 0, 1'b0);
        reset = 1'b1; #2;
        checks++;
        if (WriteData !== '0 || bufferData_in !== '0 || vec_out_valid !== 1'b0 || vector_x !== '0 || vec_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_mid got wd=%h bd=%h vvalid=%b x=%h ovf=%b exp all 0", WriteData, bufferData_in, vec_out_valid, vector_x, vec_ovf);
        end
        @(posedge CLK); #1; reset = 1'b0;
        w0 = wd_pulses;
        for (int k = 6; k < 11; k++) beat(8'h61 + 8'(k), 1'b0, 1'b0);
        idle(2);
        checks++;
        if (wd_pulses != w0 || WriteData !== '0) begin
            errors++; $display("FAIL stale_beats got pulses=%0d wd=%h exp 0 0", wd_pulses - w0, WriteData);
        end
        send_wd(8'h71);
        check_wd("wd_after_reset");
    endtask

    initial begin
        reset = 1'b1; pad_data = '0; pad_valid = 1'b0; pad_sof = 1'b0; pad_sel = 1'b0;
        vec_in_valid = 1'b0; vec_in_x = '0; vec_in_y = '0; vec_out_ready = 1'b0;
        test_reset();
        test_wd_word();
        test_bd_stall();
        test_sync_err();
        test_idle_beat();
        test_fifo_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
